// File: rtl/pwm_dead_time_generator.sv
// Turns each raw PWM channel into a complementary high/low pair with programmable
// break-before-make dead time and a shared sticky fault shutdown.
module pwm_dead_time_generator #(
    parameter int unsigned OUTPUTS    = 4,
    parameter int unsigned DEAD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OUTPUTS-1:0]    pwm_in,
    input  logic [OUTPUTS-1:0]    pwm_en_in,
    input  logic [DEAD_WIDTH-1:0] riseDeadTime,
    input  logic [DEAD_WIDTH-1:0] fallDeadTime,
    input  logic [OUTPUTS-1:0]    invertHigh,
    input  logic [OUTPUTS-1:0]    invertLow,
    input  logic                  faultEnable,
    input  logic                  fault_in,
    input  logic                  faultClear,
    input  logic                  faultIrqEnable,
    output logic [OUTPUTS-1:0]    pwm_high,
    output logic [OUTPUTS-1:0]    pwm_low,
    output logic [OUTPUTS-1:0]    pwm_oe,
    output logic [OUTPUTS-1:0]    deadActive,
    output logic                  faultFlag,
    output logic                  fault_irq
);

    typedef enum logic [2:0] {StIdle, StDead, StHigh, StLow, StFault} stateT;

    logic                faultSet;
    logic                faultFlagNext;
    logic [OUTPUTS-1:0]  highActive;
    logic [OUTPUTS-1:0]  lowActive;

    // Set dominates clear so a persisting fault can never be cleared away.
    assign faultSet = fault_in & faultEnable;

    always_comb begin
        faultFlagNext = faultFlag;
        if (faultSet) begin
            faultFlagNext = 1'b1;
        end else if (faultClear) begin
            faultFlagNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            faultFlag <= 1'b0;
        end else begin
            faultFlag <= faultFlagNext;
        end
    end

    for (genvar i = 0; i < OUTPUTS; i++) begin : gChan
        stateT                 stateQ, stateD;
        logic [DEAD_WIDTH-1:0] countQ, countD;
        logic                  targetQ, targetD;
        logic                  chanHigh, chanLow, chanDead;

        always_ff @(posedge clk) begin
            if (rst) begin
                stateQ  <= StIdle;
                countQ  <= '0;
                targetQ <= 1'b0;
            end else begin
                stateQ  <= stateD;
                countQ  <= countD;
                targetQ <= targetD;
            end
        end

        always_comb begin
            stateD  = stateQ;
            countD  = countQ;
            targetD = targetQ;
            if (faultFlag) begin
                stateD = StFault;
            end else if (!pwm_en_in[i]) begin
                stateD = StIdle;
            end else begin
                unique case (stateQ)
                    StIdle: begin
                        targetD = pwm_in[i];
                        countD  = pwm_in[i] ? riseDeadTime : fallDeadTime;
                        stateD  = StDead;
                    end
                    StHigh: begin
                        if (!pwm_in[i]) begin
                            targetD = 1'b0;
                            countD  = fallDeadTime;
                            stateD  = StDead;
                        end
                    end
                    StLow: begin
                        if (pwm_in[i]) begin
                            targetD = 1'b1;
                            countD  = riseDeadTime;
                            stateD  = StDead;
                        end
                    end
                    StDead: begin
                        // A level change mid-gap restarts the gap for the new direction.
                        if (pwm_in[i] != targetQ) begin
                            targetD = pwm_in[i];
                            countD  = pwm_in[i] ? riseDeadTime : fallDeadTime;
                        end else if (countQ == '0) begin
                            stateD = targetQ ? StHigh : StLow;
                        end else begin
                            countD = countQ - 1'b1;
                        end
                    end
                    StFault: stateD = StIdle;
                    default: stateD = StIdle;
                endcase
            end
        end

        always_comb begin
            chanHigh = 1'b0;
            chanLow  = 1'b0;
            chanDead = 1'b0;
            unique case (stateQ)
                StHigh:  chanHigh = 1'b1;
                StLow:   chanLow  = 1'b1;
                StDead:  chanDead = 1'b1;
                default: ;
            endcase
        end

        assign highActive[i] = chanHigh;
        assign lowActive[i]  = chanLow;
        assign deadActive[i] = chanDead;
    end

    assign pwm_high  = highActive ^ invertHigh;
    assign pwm_low   = lowActive ^ invertLow;
    assign pwm_oe    = pwm_en_in;
    assign fault_irq = faultFlag & faultIrqEnable;

endmodule

// File: doc/pwm_dead_time_generator.md
Name: pwm_dead_time_generator

Overview:
- Sits directly downstream of the PWM peripheral. Consumes its per-channel pwm_out and pwm_en and turns each channel into a complementary high-side/low-side pair.
- Guarantees programmable break-before-make dead time on every edge. No high/low overlap is possible.
- Provides a sticky, synchronous fault shutdown with an interrupt.
- Configuration arrives as plain ports, driven by a configuration register in the enclosing device.

Parameters:
- OUTPUTS, 4, number of PWM channels.
- DEAD_WIDTH, 8, width of the dead-time counters.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- pwm_in  input  OUTPUTS  raw PWM level per channel, from the PWM device pwm_out.
- pwm_en_in  input  OUTPUTS  channel enable, from the PWM device pwm_en.
- riseDeadTime  input  DEAD_WIDTH  cycles added after low-side off, before high-side on.
- fallDeadTime  input  DEAD_WIDTH  cycles added after high-side off, before low-side on.
- invertHigh  input  OUTPUTS  per-channel polarity inversion of the high-side output.
- invertLow  input  OUTPUTS  per-channel polarity inversion of the low-side output.
- faultEnable  input  1  allows fault_in to trip the block.
- fault_in  input  1  external fault, synchronous to clk.
- faultClear  input  1  single-cycle pulse that clears the fault latch.
- faultIrqEnable  input  1  gates fault_irq.
- pwm_high  output  OUTPUTS  high-side drive.
- pwm_low  output  OUTPUTS  low-side drive.
- pwm_oe  output  OUTPUTS  pad output enable; equals pwm_en_in.
- deadActive  output  OUTPUTS  channel is currently in DEAD.
- faultFlag  output  1  sticky fault latch.
- fault_irq  output  1  faultFlag & faultIrqEnable.

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - all channels go to IDLE; counters = 0; target = 0; faultFlag = 0.
  - highActive = lowActive = 0, so pwm_high = invertHigh and pwm_low = invertLow (combinational XOR of registered state).
  - deadActive = 0; fault_irq = 0.
- Per-channel FSM states are IDLE, DEAD, HIGH, LOW and FAULT, each with a DEAD_WIDTH counter and a 1-bit target.
- Output decode:
  - highActive = (state == HIGH); lowActive = (state == LOW).
  - pwm_high = highActive ^ invertHigh; pwm_low = lowActive ^ invertLow.
  - DEAD, IDLE and FAULT drive both sides inactive.
- Transition priority, highest first: rst > faultFlag (next state FAULT) > !pwm_en_in[i] (next state IDLE) > normal transitions.
- IDLE, when enabled: target <= pwm_in; counter <= pwm_in ? riseDeadTime : fallDeadTime; go to DEAD.
- HIGH: if pwm_in == 0, go to DEAD with target 0 and counter <= fallDeadTime.
- LOW: if pwm_in == 1, go to DEAD with target 1 and counter <= riseDeadTime.
- DEAD:
  - if pwm_in != target: target <= pwm_in and counter reloads with the dead time for the new direction.
  - else if counter == 0: go to HIGH when target = 1, LOW when target = 0.
  - else decrement the counter.
- Timing: a pwm_in edge sampled at edge t removes the old side at edge t. The new side asserts at edge t+N+1, where N is the dead time, so the gap is N+1 cycles. With N = 0 there is still a 1-cycle gap; the minimum gap is therefore always 1 cycle.
- Pulses shorter than the dead time: the reload rule extends DEAD, so a pulse shorter than its dead time never reaches the opposite side.
- Dead-time inputs are sampled only on counter load. Changing them mid-DEAD does not affect the current gap.
- Fault latch:
  - faultFlag sets when fault_in & faultEnable. It takes effect on all channels the next cycle, with both sides inactive.
  - faultClear clears faultFlag only when the set condition is false. Set wins over clear in the same cycle.
  - After clear, channels go FAULT -> IDLE and restart through DEAD.
- pwm_oe is pass-through of pwm_en_in and is not gated by fault. Polarity handles the safe level.
- Channels are fully independent except for the shared fault latch.
- Expected RTL size: roughly 150-250 lines, with a generate loop over the channels.

Test Plan:
- riseDeadTime = 3, fallDeadTime = 5, channel 0 enabled, pwm_in[0] 0 -> 1 at cycle 10, steady for 20 cycles, then back to 0:
  - pwm_low drops at cycle 10; pwm_high rises at cycle 14.
  - On the falling edge, pwm_high drops immediately and pwm_low rises 6 cycles later.
  - pwm_high & pwm_low is never 1.
- Dead times = 0, pwm_in toggled every 4 cycles -> each side is on 3 cycles, with exactly one dead cycle between sides.
- riseDeadTime = 4, from LOW, pwm_in high for 2 cycles then low -> pwm_high never asserts; pwm_low returns after fallDeadTime + 1 cycles from the falling edge.
- Channel in HIGH, faultEnable = 1, fault_in pulsed for 1 cycle:
  - all pwm_high/pwm_low go inactive next cycle; faultFlag = 1; fault_irq = 1 with faultIrqEnable set.
  - faultClear asserted while fault_in = 1 leaves the flag set.
  - faultClear asserted later clears the flag, and the channel re-enters through DEAD.
- pwm_en_in dropped during DEAD -> IDLE next cycle with deadActive = 0. Re-enabling goes through a full dead interval before either side asserts.
- invertHigh = 4'b0001, invertLow = 4'b0001, under reset -> pwm_high[0] = pwm_low[0] = 1; the waveforms from the first scenario appear inverted after reset.
